// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32 control unit.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecuteR,
        StExecuteI,
        StAluWb,
        StBeq,
        StJal,
        StHalt
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcAReg   = 2'b10;

    localparam logic [1:0] SrcBReg  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Instruction fields and control lines between the control FSM and the datapath.
interface mc_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] AluControl;
    logic       Illegal;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, AluControl, Illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, AluControl, Illegal
    );
endinterface

// File: rtl/mc_control_fsm_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp and instruction fields to the ALU's 3-bit control.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [2:0] funct3,
    input  logic       opB5,
    input  logic       funct7b5,
    output logic [2:0] aluControl,
    output logic       decodeIllegal
);

    always_comb begin
        aluControl    = AluAdd;
        decodeIllegal = 1'b0;
        case (aluOp)
            AluOpAdd: aluControl = AluAdd;
            AluOpSub: aluControl = AluSub;
            AluOpFunct: begin
                case (funct3)
                    3'b000:  aluControl = (opB5 & funct7b5) ? AluSub : AluAdd;
                    3'b010:  aluControl = AluSlt;
                    3'b110:  aluControl = AluOr;
                    3'b111:  aluControl = AluAnd;
                    default: decodeIllegal = 1'b1;
                endcase
            end
            default: aluControl = AluAdd;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the RV32 multicycle core.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unsupported instructions in a HALT state.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input logic   clk,
    input logic   reset,
    mc_ctrl_if.master bus
);

    state_e     stateQ, stateD;
    logic       pcUpdate, branch, memWrite, irWrite, regWrite, adrSrc;
    logic [1:0] aluOp, resultSrc, srcA, srcB, immSrc;
    logic [2:0] aluControl;
    logic       decodeIllegal;

    always_ff @(posedge clk) begin
        if (reset) stateQ <= StFetch;
        else       stateQ <= stateD;
    end

    always_comb begin
        stateD    = StFetch;
        pcUpdate  = 1'b0;
        branch    = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        regWrite  = 1'b0;
        adrSrc    = 1'b0;
        aluOp     = AluOpAdd;
        resultSrc = ResAluOut;
        srcA      = SrcAPc;
        srcB      = SrcBReg;
        immSrc    = ImmI;
        case (stateQ)
            StFetch: begin
                irWrite   = 1'b1;
                srcB      = SrcBFour;
                resultSrc = ResAluResult;
                pcUpdate  = 1'b1;
                stateD    = StDecode;
            end
            StDecode: begin
                srcA   = SrcAOldPc;
                srcB   = SrcBImm;
                immSrc = ImmB;
                case (bus.op)
                    OpLoad, OpStore: stateD = StMemAdr;
                    OpRtype:         stateD = StExecuteR;
                    OpItype:         stateD = StExecuteI;
                    OpBranch:        stateD = StBeq;
                    OpJal:           stateD = StJal;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:         stateD = StHalt;
`else
                    default:         stateD = StFetch;
`endif
                endcase
            end
            StMemAdr: begin
                srcA   = SrcAReg;
                srcB   = SrcBImm;
                immSrc = bus.op[5] ? ImmS : ImmI;
                stateD = bus.op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                adrSrc = 1'b1;
                stateD = StMemWb;
            end
            StMemWb: begin
                resultSrc = ResData;
                regWrite  = 1'b1;
                stateD    = StFetch;
            end
            StMemWrite: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
                stateD   = StFetch;
            end
            StExecuteR, StExecuteI: begin
                srcA  = SrcAReg;
                srcB  = (stateQ == StExecuteI) ? SrcBImm : SrcBReg;
                aluOp = AluOpFunct;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                stateD = decodeIllegal ? StHalt : StAluWb;
`else
                stateD = StAluWb;
`endif
            end
            StAluWb: begin
                regWrite = 1'b1;
                stateD   = StFetch;
            end
            StBeq: begin
                srcA   = SrcAReg;
                aluOp  = AluOpSub;
                branch = 1'b1;
                stateD = StFetch;
            end
            StJal: begin
                srcA     = SrcAOldPc;
                srcB     = SrcBFour;
                pcUpdate = 1'b1;
                stateD   = StAluWb;
            end
            StHalt:  stateD = StHalt;
            default: stateD = StFetch;
        endcase
    end

    alu_decoder uAluDecoder (
        .aluOp        (aluOp),
        .funct3       (bus.funct3),
        .opB5         (bus.op[5]),
        .funct7b5     (bus.funct7b5),
        .aluControl   (aluControl),
        .decodeIllegal(decodeIllegal)
    );

    // Write enables are masked while reset is held, whatever state the register holds.
    assign bus.PCWrite    = (pcUpdate | (branch & bus.Zero)) & ~reset;
    assign bus.IRWrite    = irWrite & ~reset;
    assign bus.MemWrite   = memWrite & ~reset;
    assign bus.RegWrite   = regWrite & ~reset;
    assign bus.AdrSrc     = adrSrc;
    assign bus.ResultSrc  = resultSrc;
    assign bus.ALUSrcA    = srcA;
    assign bus.ALUSrcB    = srcB;
    assign bus.ImmSrc     = immSrc;
    assign bus.AluControl = aluControl;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign bus.Illegal = (stateQ == StHalt);
`else
    logic unusedDecodeIllegal;
    assign unusedDecodeIllegal = decodeIllegal;
    assign bus.Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Table-driven, scoreboarded bench for mc_control_fsm; honours MC_CTRL_ILLEGAL_TRAP_EN.
module tb_mc_control_fsm;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        zero;
        logic [16:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   nCompared = 0;
    int   nMismatched = 0;
    vec_t tbl[$];
    logic [16:0] sbExp[$];
    logic [16:0] sbMask[$];

    mc_ctrl_if bus ();

    mc_control_fsm dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    localparam logic [16:0] MaskAll = 17'h1ffff;
    // PCWrite, MemWrite, IRWrite, RegWrite only.
    localparam logic [16:0] MaskWe  = 17'b1_0_1_1_1_00_00_00_00_000_0;

    function automatic logic [16:0] v(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] imm, input logic [2:0] alu,
                                      input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
    endfunction

    function automatic logic [16:0] outVec();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.AluControl,
                bus.Illegal};
    endfunction

    logic [16:0] vF, vD, vMaL, vMaS, vMr, vMwb, vMw, vAw, vJ, vHalt;

    function automatic logic [16:0] vEr(input logic [2:0] alu);
        return v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 0);
    endfunction

    function automatic logic [16:0] vEi(input logic [2:0] alu);
        return v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 0);
    endfunction

    function automatic logic [16:0] vBq(input logic z);
        return v(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0);
    endfunction

    // Pushes FETCH and DECODE rows, then n instruction-specific rows.
    task automatic addInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input int n, input logic [16:0] e0,
                            input logic [16:0] e1, input logic [16:0] e2);
        logic [16:0] es[3];
        es[0] = e0; es[1] = e1; es[2] = e2;
        tbl.push_back('{o, f3, f7, z, vF});
        tbl.push_back('{o, f3, f7, z, vD});
        for (int k = 0; k < n; k++) tbl.push_back('{o, f3, f7, z, es[k]});
    endtask

    task automatic check(input string name);
        logic [16:0] e, m, a;
        e = sbExp.pop_front();
        m = sbMask.pop_front();
        a = outVec();
        nCompared++;
        if ((a & m) !== (e & m)) begin
            nMismatched++;
            $display("FAIL %s: got %b want %b (mask %b)", name, a, e, m);
        end
    endtask

    task automatic cyc(input string name, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic rst,
                       input logic [16:0] exp, input logic [16:0] mask);
        bus.op = o;
        bus.funct3 = f3;
        bus.funct7b5 = f7;
        bus.Zero = z;
        reset = rst;
        sbExp.push_back(exp);
        sbMask.push_back(mask);
        @(negedge clk);
        check(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vF    = v(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
        vD    = v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0);
        vMaL  = v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
        vMaS  = v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0);
        vMr   = v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        vMwb  = v(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        vMw   = v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        vAw   = v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        vJ    = v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 0);
        vHalt = v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1);

        addInstr(7'b0000011, 3'b010, 0, 1, 3, vMaL, vMr, vMwb);          // lw
        addInstr(7'b0100011, 3'b010, 0, 0, 2, vMaS, vMw, 17'd0);         // sw
        addInstr(7'b0110011, 3'b000, 1, 0, 2, vEr(3'b001), vAw, 17'd0);  // sub
        addInstr(7'b0110011, 3'b000, 0, 1, 2, vEr(3'b000), vAw, 17'd0);  // add
        addInstr(7'b0110011, 3'b010, 0, 0, 2, vEr(3'b101), vAw, 17'd0);  // slt
        addInstr(7'b0110011, 3'b110, 0, 0, 2, vEr(3'b011), vAw, 17'd0);  // or
        addInstr(7'b0110011, 3'b111, 0, 0, 2, vEr(3'b010), vAw, 17'd0);  // and
        addInstr(7'b0010011, 3'b000, 1, 0, 2, vEi(3'b000), vAw, 17'd0);  // addi, bit30 ignored
        addInstr(7'b0010011, 3'b110, 0, 0, 2, vEi(3'b011), vAw, 17'd0);  // ori
        addInstr(7'b1100011, 3'b000, 0, 1, 1, vBq(1), 17'd0, 17'd0);     // beq taken
        addInstr(7'b1100011, 3'b000, 0, 0, 1, vBq(0), 17'd0, 17'd0);     // beq not taken
        addInstr(7'b1101111, 3'b000, 0, 1, 2, vJ, vAw, 17'd0);           // jal

        bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 0; bus.Zero = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cyc("initial_reset", 7'b0000011, 3'b0, 0, 0, 1, 17'd0, MaskWe);

        for (int i = 0; i < tbl.size(); i++)
            cyc($sformatf("vec%0d", i), tbl[i].op, tbl[i].funct3, tbl[i].funct7b5,
                tbl[i].zero, 0, tbl[i].exp, MaskAll);
        cyc("fetch_after_table", 7'b0, 3'b0, 0, 0, 0, vF, MaskAll);

        // Reset held three cycles, starting while in MEMWB where RegWrite would be high.
        cyc("pre_lw_dec", 7'b0000011, 3'b010, 0, 0, 0, vD, MaskAll);
        cyc("pre_lw_ma", 7'b0000011, 3'b010, 0, 0, 0, vMaL, MaskAll);
        cyc("pre_lw_mr", 7'b0000011, 3'b010, 0, 0, 0, vMr, MaskAll);
        repeat (3) cyc("reset_midinstr", 7'b0000011, 3'b010, 0, 1, 1, 17'd0, MaskWe);
        cyc("fetch_after_reset", 7'b0000011, 3'b010, 0, 0, 0, vF, MaskAll);

        // Unknown opcode.
        cyc("badop_dec", 7'b1111111, 3'b000, 0, 0, 0, vD, MaskAll);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        repeat (4) cyc("badop_halt", 7'b1111111, 3'b000, 0, 1, 0, vHalt, MaskAll);
        cyc("badop_reset", 7'b1111111, 3'b000, 0, 0, 1, 17'd0, MaskWe);
        cyc("badop_recover", 7'b0110011, 3'b001, 0, 0, 0, vF, MaskAll);
`else
        cyc("badop_fetch", 7'b0110011, 3'b001, 0, 0, 0, vF, MaskAll);
`endif

        // R-type with unsupported funct3.
        cyc("badf3_dec", 7'b0110011, 3'b001, 0, 0, 0, vD, MaskAll);
        cyc("badf3_exec", 7'b0110011, 3'b001, 0, 0, 0, vEr(3'b000), MaskAll);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        repeat (2) cyc("badf3_halt", 7'b0110011, 3'b001, 0, 0, 0, vHalt, MaskAll);
        cyc("badf3_reset", 7'b0110011, 3'b001, 0, 0, 1, 17'd0, MaskWe);
`else
        cyc("badf3_wb", 7'b0110011, 3'b001, 0, 0, 0, vAw, MaskAll);
`endif
        cyc("badf3_fetch", 7'b0, 3'b0, 0, 0, 0, vF, MaskAll);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
